// File: rtl/mem_wait_responder.sv
// mem_wait_responder: single-outstanding memory target with programmable wait states.
// Latency: request sampled at edge N, ready_o high for the cycle after edge N+WAIT_CYCLES.
// Backpressure: one request at a time; valid_i is ignored while busy_o is high.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (also clears memory)
//   valid_i, wr_rd_i    request strobe, 1 = write / 0 = read
//   addr_i, wdata_i     word address and write data, captured on acceptance
//   rdata_o             last read data, registered, held across writes/idle
//   ready_o             one-cycle completion pulse, registered
//   busy_o              request accepted and not yet completed
//   err_o               completion was a rejected write (protected region)
//
// Optional feature: define MEM_WR_PROTECT_EN to make addresses >= RO_BASE
// read-only. Without it all addresses are writable and err_o stays 0.

module mem_wait_responder #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int WAIT_CYCLES = 2,
  parameter int RO_BASE     = 48
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0]          WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic                ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [ADDR_WIDTH:0] RO_BASE_L = (ADDR_WIDTH+1)'(RO_BASE);
`ifdef MEM_WR_PROTECT_EN
  localparam logic                PROTECT_EN = 1'b1;
`else
  localparam logic                PROTECT_EN = 1'b0;
`endif

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [WIDTH-1:0]        req_wdata;
  logic [WIDTH-1:0]        mem [DEPTH];

  // Request seen by the commit path. With zero wait states the commit happens
  // on the accepting edge itself, so the live inputs stand in for the
  // not-yet-captured request registers.
  logic                    cm_wr;
  logic [ADDR_WIDTH-1:0]   cm_addr;
  logic [WIDTH-1:0]        cm_wdata;
  logic                    cm_protect;
  logic                    do_commit;

  always_comb begin
    cm_wr    = req_wr;
    cm_addr  = req_addr;
    cm_wdata = req_wdata;
    if (state == ST_IDLE) begin
      cm_wr    = wr_rd_i;
      cm_addr  = addr_i;
      cm_wdata = wdata_i;
    end
  end

  // Zero-extend the address so RO_BASE == DEPTH (nothing protected) still compares correctly.
  assign cm_protect = PROTECT_EN & cm_wr & ({1'b0, cm_addr} >= RO_BASE_L);

  assign do_commit = ((state == ST_IDLE) && valid_i && ZERO_WAIT) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_o   <= '0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            req_wr    <= wr_rd_i;
            req_addr  <= addr_i;
            req_wdata <= wdata_i;
            wait_cnt  <= WAIT_LD;
            busy_o    <= 1'b1;
            state     <= ZERO_WAIT ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase

      // Commit on the edge that enters RESP; ready_o/err_o become visible in RESP.
      if (do_commit) begin
        if (cm_wr) begin
          if (!cm_protect) begin
            mem[cm_addr] <= cm_wdata;
          end
        end else begin
          rdata_o <= mem[cm_addr];
        end
        ready_o <= 1'b1;
        err_o   <= cm_protect;
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: DUT A uses WAIT_CYCLES=2, DUT B uses
// WAIT_CYCLES=0. Inputs change and outputs are sampled on the falling edge.

module tb_mem_wait_responder;

`ifdef MEM_WR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        valid_a, valid_b;
  logic        wr_rd;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, busy_a, busy_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wait_responder #(.WIDTH(16), .DEPTH(64), .WAIT_CYCLES(2), .RO_BASE(48)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .valid_i(valid_a), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata_a), .ready_o(ready_a), .busy_o(busy_a), .err_o(err_a)
  );

  mem_wait_responder #(.WIDTH(16), .DEPTH(64), .WAIT_CYCLES(0), .RO_BASE(48)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .valid_i(valid_b), .wr_rd_i(wr_rd), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata_b), .ready_o(ready_b), .busy_o(busy_b), .err_o(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, drop valid after the sampling edge, then watch 8 cycles.
  task automatic do_req(input bit sel, input bit wr, input logic [5:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er,
                        output int lat, output int npulse, output int nbusy);
    logic r, b;
    @(negedge clk);
    wr_rd = wr; addr = a; wdata = d;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    lat = -1; npulse = 0; nbusy = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      valid_a = 1'b0; valid_b = 1'b0;
      r = sel ? ready_b : ready_a;
      b = sel ? busy_b : busy_a;
      if (r) begin
        npulse++;
        if (lat < 0) begin
          lat = k;
          rd = sel ? rdata_b : rdata_a;
          er = sel ? err_b : err_a;
        end
      end
      if (b) nbusy++;
    end
  endtask

  initial begin : stim
    logic [15:0] rd, expd, last_rd;
    logic        er;
    int          lat, np, nb, total;

    rst_a = 1'b1; rst_b = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
    wr_rd = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset values
    chk("rst_ready", {31'd0, ready_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_a}, 32'd0);
    chk("rst_b_ready", {31'd0, ready_b}, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);

    // Read of cleared memory
    do_req(1'b0, 1'b0, 6'd5, 16'h0, rd, er, lat, np, nb);
    chk("rd0_lat", lat, 32'd3);
    chk("rd0_data", {16'd0, rd}, 32'd0);
    chk("rd0_err", {31'd0, er}, 32'd0);
    chk("rd0_pulses", np, 32'd1);
    chk("rd0_busy", nb, 32'd3);

    // Write then read same address
    do_req(1'b0, 1'b1, 6'd5, 16'hA5A5, rd, er, lat, np, nb);
    chk("wr5_lat", lat, 32'd3);
    chk("wr5_pulses", np, 32'd1);
    chk("wr5_busy", nb, 32'd3);
    chk("wr5_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 1'b0, 6'd5, 16'h0, rd, er, lat, np, nb);
    chk("rd5_data", {16'd0, rd}, 32'h0000A5A5);
    chk("rd5_pulses", np, 32'd1);
    chk("rd5_busy", nb, 32'd3);

    // Full sweep: write addr*0x0101 everywhere, then read back
    total = 0;
    for (int i = 0; i < 64; i++) begin
      do_req(1'b0, 1'b1, 6'(i), 16'(i * 16'h0101), rd, er, lat, np, nb);
      total += np;
      chk("sweep_wr_err", {31'd0, er}, {31'd0, (PROT && i >= 48)});
    end
    for (int i = 0; i < 64; i++) begin
      do_req(1'b0, 1'b0, 6'(i), 16'h0, rd, er, lat, np, nb);
      total += np;
      expd = (PROT && i >= 48) ? 16'h0 : 16'(i * 16'h0101);
      chk("sweep_rd", {16'd0, rd}, {16'd0, expd});
    end
    chk("sweep_pulses", total, 32'd128);
    last_rd = PROT ? 16'h0 : 16'h3F3F;

    // rdata holds its last read value through a write and idle cycles
    do_req(1'b0, 1'b1, 6'd1, 16'hFFFF, rd, er, lat, np, nb);
    chk("rdata_hold", {16'd0, rdata_a}, {16'd0, last_rd});

    // Reset during WAIT of a write: aborted, no ready, memory cleared
    @(negedge clk);
    wr_rd = 1'b1; addr = 6'd7; wdata = 16'h1234; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    chk("abort_busy_before", {31'd0, busy_a}, 32'd1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort_busy_after", {31'd0, busy_a}, 32'd0);
    chk("abort_rdata_clr", {16'd0, rdata_a}, 32'd0);
    np = 0;
    for (int k = 0; k < 6; k++) begin
      if (ready_a) np++;
      @(negedge clk);
    end
    chk("abort_no_ready", np, 32'd0);
    do_req(1'b0, 1'b0, 6'd7, 16'h0, rd, er, lat, np, nb);
    chk("abort_rd7", {16'd0, rd}, 32'd0);
    do_req(1'b0, 1'b0, 6'd1, 16'h0, rd, er, lat, np, nb);
    chk("abort_mem_clr", {16'd0, rd}, 32'd0);

    if (PROT) begin
      do_req(1'b0, 1'b1, 6'd50, 16'hBEEF, rd, er, lat, np, nb);
      chk("prot_wr50_lat", lat, 32'd3);
      chk("prot_wr50_err", {31'd0, er}, 32'd1);
      do_req(1'b0, 1'b0, 6'd50, 16'h0, rd, er, lat, np, nb);
      chk("prot_rd50", {16'd0, rd}, 32'd0);
      chk("prot_rd50_err", {31'd0, er}, 32'd0);
      do_req(1'b0, 1'b1, 6'd47, 16'hBEEF, rd, er, lat, np, nb);
      chk("prot_wr47_err", {31'd0, er}, 32'd0);
      do_req(1'b0, 1'b0, 6'd47, 16'h0, rd, er, lat, np, nb);
      chk("prot_rd47", {16'd0, rd}, 32'h0000BEEF);
    end

    // Zero wait states, back-to-back writes with valid held high
    total = 0;
    @(negedge clk);
    wr_rd = 1'b1; addr = 6'd0; wdata = 16'h1000; valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_ready", {31'd0, ready_b}, 32'd1);
      chk("b2b_busy", {31'd0, busy_b}, 32'd1);
      if (ready_b) total++;
      addr = 6'(i + 1); wdata = 16'(16'h1000 + i + 1);
      if (i == 3) valid_b = 1'b0;
      @(negedge clk);
      chk("b2b_idle_ready", {31'd0, ready_b}, 32'd0);
      chk("b2b_idle_busy", {31'd0, busy_b}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ready_b) total++;
    end
    chk("b2b_pulses", total, 32'd4);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b1, 1'b0, 6'(i), 16'h0, rd, er, lat, np, nb);
      expd = (i < 4) ? 16'(16'h1000 + i) : 16'h0;
      chk("b2b_rd", {16'd0, rd}, {16'd0, expd});
      chk("b2b_rd_lat", lat, 32'd1);
      chk("b2b_rd_busy", nb, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wait_responder.md
# mem_wait_responder

Synthesizable responder for the single-outstanding valid/ready memory request interface used by the memory testbenches. It accepts one read or write request at a time from an initiator, stalls for a programmable number of wait states, then completes the request with a one-cycle `ready_o` pulse. It sits on the target side of the interface and is the responder used for initiator/bench bring-up with non-zero latency.

## Interface
- `WIDTH`, 16, data word width in bits
- `DEPTH`, 64, number of words
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width
- `WAIT_CYCLES`, 2, wait states per request; legal range 0..15
- `RO_BASE`, 48, first read-only address; used only when `MEM_WR_PROTECT_EN` is defined

- `clk_i`  in  1  single clock; all logic on posedge
- `rst_i`  in  1  synchronous, active-high reset
- `valid_i`  in  1  request present
- `wr_rd_i`  in  1  1 = write, 0 = read
- `addr_i`  in  `ADDR_WIDTH`  word address
- `wdata_i`  in  `WIDTH`  write data
- `rdata_o`  out  `WIDTH`  read data, registered
- `ready_o`  out  1  completion pulse, registered
- `busy_o`  out  1  request accepted but not yet completed
- `err_o`  out  1  completion was a rejected write; always 0 without the macro

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: at a posedge with `valid_i`=1, capture `addr_i`, `wr_rd_i`, `wdata_i` into request registers. Load the 4-bit wait counter with `WAIT_CYCLES`. Go to WAIT, or go directly to RESP when `WAIT_CYCLES`=0. Inputs are ignored outside IDLE.
- WAIT: decrement the counter each cycle. When the counter is 1, the next edge enters RESP.
- Commit: happens at the edge entering RESP, using the captured request.
  - Write: `mem[addr] <= wdata`.
  - Read: `rdata_o <= mem[addr]`.
  - At the same edge, `ready_o` is set to 1.
- RESP: lasts exactly one cycle with `ready_o`=1, then returns to IDLE with `ready_o` back to 0.
- `busy_o`=1 in WAIT and RESP.
- `rdata_o` holds its last read value through writes and idle cycles.
- Initiator rule: at the edge where `ready_o` is sampled high, the initiator must drop `valid_i` or present the next request. A request still held in IDLE is treated as a new transaction; duplicates are the initiator's fault, and the block does not filter them.
- Write then read of the same address across two transactions returns the new data. There is no forwarding hazard because only one request is outstanding.

## Timing
- Reset values: state IDLE, `ready_o`=0, `rdata_o`=0, `busy_o`=0, `err_o`=0, wait counter 0. All memory words are cleared to 0 at reset.
- Latency: the request is sampled at edge N. `ready_o` is high for the cycle following edge N+`WAIT_CYCLES`. That is `WAIT_CYCLES`+1 cycles, and exactly one cycle of `ready_o` per accepted request.
- Throughput: at most one request per `WAIT_CYCLES`+2 cycles, because IDLE occupies one cycle between requests.
- Reset mid-operation: `rst_i` at any edge forces the reset values, including clearing memory. A request accepted but not yet committed is dropped, no `ready_o` is produced, and a write from it never occurs.
- Address wrap: none. All `ADDR_WIDTH` values below `DEPTH` are legal. When `DEPTH` is a power of two, every address is in range.

## Configuration
- `MEM_WR_PROTECT_EN` defined:
  - A write to any address ≥ `RO_BASE` does not modify memory.
  - It still completes with normal latency, with `ready_o`=1 and `err_o`=1 in the same cycle.
  - `err_o` is 0 for all other completions.
  - Reads of protected addresses behave normally.
- `MEM_WR_PROTECT_EN` undefined: all addresses are writable, `err_o` is constant 0, and `RO_BASE` is unused.

## Test plan
- Reset, then read addr 5 → `ready_o` pulses 3 cycles after sampling (`WAIT_CYCLES`=2), `rdata_o`=0x0000, `err_o`=0.
- Write 0xA5A5 to addr 5, then read addr 5 → each `ready_o` is a single-cycle pulse, read returns 0xA5A5, `busy_o` high for exactly 3 cycles per request.
- Write addrs 0..63 with value (addr×0x0101), then read all 64 → every read matches, with 64 + 64 `ready_o` pulses total.
- Rebuild with `WAIT_CYCLES`=0, then run back-to-back writes to addrs 0..3 → `ready_o` on the cycle after each sample, one IDLE cycle between requests, no duplicate writes.
- Assert `rst_i` during WAIT of a write of 0x1234 to addr 7, then read addr 7 → no `ready_o` for the aborted request, read returns 0x0000.
- With `MEM_WR_PROTECT_EN` defined: write 0xBEEF to addr 50, then read addr 50 → write completes with `ready_o`=1 and `err_o`=1, read returns 0x0000 with `err_o`=0. Write 0xBEEF to addr 47 → `err_o`=0, read-back 0xBEEF.
